// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed result per cycle from N_REQ
// functional units in round-robin order and registers it onto the CDB.
// A flush blocks all grants and empties the CDB register during
// mispredict recovery.
module cdb_arbiter #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4,
  parameter int N_REQ     = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*TAG_WIDTH-1:0] req_tag,
  input  logic [N_REQ*XLEN-1:0]      req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       flush,
  output logic                       cdb_enable,
  output logic [TAG_WIDTH-1:0]       cdb_tag,
  output logic [XLEN-1:0]            cdb_data,
  output logic [ID_WIDTH-1:0]        cdb_grant_id
);

  // Index of the highest-priority unit for the next arbitration.
  logic [ID_WIDTH-1:0]  rr_ptr;

  logic                 win_found;
  logic [ID_WIDTH-1:0]  win_id;
  logic [TAG_WIDTH-1:0] win_tag;
  logic [XLEN-1:0]      win_data;
  logic [ID_WIDTH-1:0]  nxt_ptr;
  logic                 grant;

  // Round-robin search: first pass covers rr_ptr..N_REQ-1, the second pass
  // wraps to 0..rr_ptr-1 (it only fires when the first pass found nothing).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_tag   = '0;
    win_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        win_data  = req_data[i*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        win_data  = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // One-hot grant back to the units; silent during flush and reset. The
  // pointer wraps explicitly so non-power-of-two N_REQ works.
  always_comb begin
    grant     = win_found && !flush && !reset;
    req_ready = '0;
    if (grant) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
    end
    nxt_ptr = (win_id == ID_WIDTH'(N_REQ-1)) ? '0 : win_id + 1'b1;
  end

  // CDB register and arbitration pointer. Flush and idle both empty the
  // broadcast; only a real grant moves the pointer and the grant id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_enable   <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      cdb_grant_id <= '0;
      rr_ptr       <= '0;
    end else if (grant) begin
      cdb_enable   <= 1'b1;
      cdb_tag      <= win_tag;
      cdb_data     <= win_data;
      cdb_grant_id <= win_id;
      rr_ptr       <= nxt_ptr;
    end else begin
      cdb_enable   <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-unit instance checked against a reference
// round-robin model through a scoreboard queue, plus a 3-unit instance
// exercising non-power-of-two wrap and a mid-stream asynchronous reset.
module tb_cdb_arbiter;

  logic        clk;
  logic        reset;

  // 4-unit instance
  logic [3:0]   req_valid;
  logic [15:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         flush;
  logic         cdb_enable;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_grant_id;

  // 3-unit instance
  logic [2:0]   r3_valid;
  logic [11:0]  r3_tag;
  logic [95:0]  r3_data;
  logic [2:0]   r3_ready;
  logic         r3_flush;
  logic         r3_enable;
  logic [3:0]   r3_cdb_tag;
  logic [31:0]  r3_cdb_data;
  logic [1:0]   r3_grant_id;

  cdb_arbiter #(.XLEN(32), .TAG_WIDTH(4), .N_REQ(4), .ID_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .flush(flush),
    .cdb_enable(cdb_enable), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_grant_id(cdb_grant_id)
  );

  cdb_arbiter #(.XLEN(32), .TAG_WIDTH(4), .N_REQ(3), .ID_WIDTH(2)) dut3 (
    .clk(clk), .reset(reset), .req_valid(r3_valid), .req_tag(r3_tag),
    .req_data(r3_data), .req_ready(r3_ready), .flush(r3_flush),
    .cdb_enable(r3_enable), .cdb_tag(r3_cdb_tag), .cdb_data(r3_cdb_data),
    .cdb_grant_id(r3_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  tags  [4];
  logic [31:0] datas [4];
  int          m_ptr;
  logic [1:0]  m_id;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic pack4();
    for (int i = 0; i < 4; i++) begin
      req_tag[i*4 +: 4]    = tags[i];
      req_data[i*32 +: 32] = datas[i];
    end
  endtask

  // Drive one cycle on the 4-unit DUT: model predicts the grant, pushes the
  // expected CDB contents, and the value is popped after the edge.
  task automatic cycle4(input logic [3:0] vld, input logic fl);
    int         w;
    int         idx;
    logic [3:0] er;
    exp_t       e;
    exp_t       o;
    req_valid = vld;
    flush     = fl;
    pack4();
    w = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (w < 0 && vld[idx]) w = idx;
    end
    if (w >= 0 && !fl) begin
      er     = 4'b0001 << w;
      e.en   = 1'b1;
      e.tag  = tags[w];
      e.data = datas[w];
      e.id   = 2'(w);
      m_ptr  = (w + 1) % 4;
      m_id   = 2'(w);
    end else begin
      er     = 4'b0000;
      e.en   = 1'b0;
      e.tag  = 4'h0;
      e.data = 32'h0;
      e.id   = m_id;
    end
    sb.push_back(e);
    #1;
    check("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      check("cdb_enable",   64'(cdb_enable),   64'(o.en));
      check("cdb_tag",      64'(cdb_tag),      64'(o.tag));
      check("cdb_data",     64'(cdb_data),     64'(o.data));
      check("cdb_grant_id", 64'(cdb_grant_id), 64'(o.id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 4'b0;
    req_tag   = '0;
    req_data  = '0;
    flush     = 1'b0;
    r3_valid  = 3'b0;
    r3_tag    = '0;
    r3_data   = '0;
    r3_flush  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tags[i]  = 4'(i + 9);
      datas[i] = $urandom;
    end
    tags[0]  = 4'd5;
    datas[0] = 32'hDEADBEEF;
    pack4();
    req_valid = 4'b0001;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_enable", 64'(cdb_enable),   64'd0);
    check("rst_tag",    64'(cdb_tag),      64'd0);
    check("rst_data",   64'(cdb_data),     64'd0);
    check("rst_id",     64'(cdb_grant_id), 64'd0);
    check("rst_ready",  64'(req_ready),    64'd0);
    check("rst3_enable", 64'(r3_enable),   64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_ptr = 0;
    m_id  = 2'd0;

    // First grant after reset: unit 0, tag 5, DEADBEEF
    cycle4(4'b0001, 1'b0);

    // Round-robin with all units valid
    for (int i = 0; i < 4; i++) tags[i] = 4'(i + 1);
    for (int c = 0; c < 8; c++) cycle4(4'b1111, 1'b0);

    // Pointer skip: get rr_ptr to 1, then 1001 grants 3 then 0
    cycle4(4'b0001, 1'b0);
    cycle4(4'b1001, 1'b0);
    cycle4(4'b1001, 1'b0);

    // Flush for two cycles, then grants resume at 1 then 2
    for (int c = 0; c < 2; c++) cycle4(4'b0110, 1'b1);
    cycle4(4'b0110, 1'b0);
    cycle4(4'b0100, 1'b0);

    // Idle after a broadcast: enable drops, grant id holds
    cycle4(4'b0000, 1'b0);
    cycle4(4'b0000, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 4; i++) datas[i] = $urandom;
      cycle4(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
    end
    cycle4(4'b0000, 1'b0);

    // Three-unit instance: wrap-around 0,1,2,0
    for (int i = 0; i < 3; i++) begin
      r3_tag[i*4 +: 4]    = 4'(i + 1);
      r3_data[i*32 +: 32] = 32'h1000 + 32'(i);
    end
    r3_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int ge;
      ge = (g == 3) ? 0 : g;
      #1;
      check("r3_ready", 64'(r3_ready), 64'(3'b001 << ge));
      @(posedge clk);
      #1;
      check("r3_enable", 64'(r3_enable),   64'd1);
      check("r3_id",     64'(r3_grant_id), 64'(ge));
      check("r3_tag",    64'(r3_cdb_tag),  64'(ge + 1));
      check("r3_data",   64'(r3_cdb_data), 64'(32'h1000 + 32'(ge)));
    end

    // Asynchronous reset pulse mid-stream
    #1 reset = 1'b1;
    #1;
    check("r3_rst_enable", 64'(r3_enable),   64'd0);
    check("r3_rst_id",     64'(r3_grant_id), 64'd0);
    check("r3_rst_ready",  64'(r3_ready),    64'd0);
    #1 reset = 1'b0;
    #1;
    check("r3_post_ready", 64'(r3_ready), 64'd1);
    @(posedge clk);
    #1;
    check("r3_post_enable", 64'(r3_enable),   64'd1);
    check("r3_post_id",     64'(r3_grant_id), 64'd0);
    check("r3_post_tag",    64'(r3_cdb_tag),  64'd1);

    // Flush on the three-unit instance
    r3_flush = 1'b1;
    #1;
    check("r3_flush_ready", 64'(r3_ready), 64'd0);
    @(posedge clk);
    #1;
    check("r3_flush_enable", 64'(r3_enable), 64'd0);
    check("r3_flush_tag",    64'(r3_cdb_tag), 64'd0);
    r3_flush = 1'b0;
    #1;
    check("r3_unflush_ready", 64'(r3_ready), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
